// File: rtl/sr_seq_pkg.sv
// Shared types and constants for the set/reset bank sequencer.
package sr_seq_pkg;

    // Sequencer phases; every phase except IDLE keeps busy high.
    typedef enum logic [2:0] {
        IDLE,
        ASSERT,
        RELR,
        RELS,
        DONE
    } sr_state_e;

    // Width of the shared phase down-counter.
    localparam int CNT_W   = 8;
    localparam int CYC_MIN = 1;
    localparam int CYC_MAX = (1 << CNT_W) - 1;

    // True when a phase length fits the counter and is non-zero.
    function automatic bit cyc_ok(input int v);
        return (v >= CYC_MIN) && (v <= CYC_MAX);
    endfunction

    // Counter load value for a phase lasting v cycles.
    function automatic logic [CNT_W-1:0] cyc_load(input int v);
        return CNT_W'(v - 1);
    endfunction

endpackage

// File: rtl/sr_seq_rr_arb.sv
// Two-way round-robin arbiter; the last winner loses the next tie.
module sr_seq_rr_arb
    import sr_seq_pkg::*;
(
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       owner
);

    logic last_q;

    // Favour the requester that did not win last time.
    always_comb begin
        gnt = 2'b00;
        if (last_q) begin
            gnt[0] = req[0];
            gnt[1] = req[1] & ~req[0];
        end else begin
            gnt[1] = req[1];
            gnt[0] = req[0] & ~req[1];
        end
    end

    assign owner = gnt[1];

    // Remember the winner, only when a grant is actually taken.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN)
            last_q <= 1'b1;
        else if (advance && (|gnt))
            last_q <= owner;
    end

endmodule

// File: rtl/sr_seq_ctrl.sv
// Set/reset sequencer for an async set/reset flop bank: pulse, staggered
// release of RESETN then SETN, recovery window, then clock re-enable.
module sr_seq_ctrl
    import sr_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1,
    parameter int REC_CYC   = 2
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] pat0,
    input  logic [WIDTH-1:0] pat1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] bank_setn,
    output logic [WIDTH-1:0] bank_resetn,
    output logic             bank_clk_en,
    output logic             busy
);

    if (!cyc_ok(PULSE_CYC) || !cyc_ok(GAP_CYC) || !cyc_ok(REC_CYC)) begin : g_bad_param
        $error("sr_seq_ctrl: PULSE_CYC, GAP_CYC and REC_CYC must be 1..255");
    end

    localparam logic [CNT_W-1:0] LD_P = cyc_load(PULSE_CYC);
    localparam logic [CNT_W-1:0] LD_G = cyc_load(GAP_CYC);
    localparam logic [CNT_W-1:0] LD_R = cyc_load(REC_CYC);

    sr_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] pat_q;
    logic             own_q;
    logic             own_vld_q;   // low for the post-reset init sequence
    logic [WIDTH-1:0] setn_q;
    logic [WIDTH-1:0] resetn_q;
    logic             clk_en_q;
    logic [1:0]       ack_q;
    logic             busy_q;

    logic [1:0]       gnt;
    logic             owner;
    logic [WIDTH-1:0] pat_sel;

    sr_seq_rr_arb u_arb (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .req     ({req1, req0}),
        .advance (state_q == IDLE),
        .gnt     (gnt),
        .owner   (owner)
    );

    assign pat_sel = owner ? pat1 : pat0;

    // Sequencer FSM with the phase counter and all registered outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= ASSERT;
            cnt_q     <= LD_P;
            pat_q     <= '0;
            own_q     <= 1'b0;
            own_vld_q <= 1'b0;
            setn_q    <= '1;
            resetn_q  <= '0;
            clk_en_q  <= 1'b0;
            ack_q     <= 2'b00;
            busy_q    <= 1'b1;
        end else begin
            ack_q <= 2'b00;
            unique case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        state_q   <= ASSERT;
                        cnt_q     <= LD_P;
                        pat_q     <= pat_sel;
                        own_q     <= owner;
                        own_vld_q <= 1'b1;
                        setn_q    <= ~pat_sel;
                        resetn_q  <= pat_sel;
                        clk_en_q  <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ASSERT: begin
                    setn_q   <= ~pat_q;
                    resetn_q <= pat_q;
                    if (cnt_q == '0) begin
                        state_q  <= RELR;
                        cnt_q    <= LD_G;
                        resetn_q <= '1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RELR: begin
                    if (cnt_q == '0) begin
                        state_q  <= RELS;
                        cnt_q    <= LD_R;
                        setn_q   <= '1;
                        clk_en_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RELS: begin
                    if (cnt_q == '0) begin
                        state_q  <= DONE;
                        clk_en_q <= 1'b1;
                        if (own_vld_q)
                            ack_q[own_q] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    own_vld_q <= 1'b0;
                    setn_q    <= '1;
                    resetn_q  <= '1;
                    clk_en_q  <= 1'b1;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack0        = ack_q[0];
    assign ack1        = ack_q[1];
    assign bank_setn   = setn_q;
    assign bank_resetn = resetn_q;
    assign bank_clk_en = clk_en_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sr_seq_ctrl.sv
// Bench for sr_seq_ctrl: timeline model compared every cycle, plus literal checks.
module tb_sr_seq_ctrl;
    localparam int W = 8, P = 2, G = 1, R = 2;
    localparam int DONE_T = P + G + R;

    logic       CLK = 1'b0, RESETN = 1'b1, req0 = 1'b0, req1 = 1'b0;
    logic [7:0] pat0 = 8'h00, pat1 = 8'h00;
    logic       ack0, ack1, bank_clk_en, busy;
    logic [7:0] bank_setn, bank_resetn;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;

    sr_seq_ctrl #(.WIDTH(W), .PULSE_CYC(P), .GAP_CYC(G), .REC_CYC(R)) dut (
        .CLK(CLK), .RESETN(RESETN), .req0(req0), .req1(req1),
        .pat0(pat0), .pat1(pat1), .ack0(ack0), .ack1(ack1),
        .bank_setn(bank_setn), .bank_resetn(bank_resetn),
        .bank_clk_en(bank_clk_en), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Edge count since the last reset release.
    always @(posedge CLK or negedge RESETN)
        if (!RESETN) cyc <= 0; else cyc <= cyc + 1;

    // Model: time since the current sequence started, plus who owns it.
    bit         m_act, m_own, m_vld, m_ptr;
    int         m_t;
    logic [7:0] m_pat;
    int         m_glog[$];
    wire        m_win = (req0 && req1) ? ~m_ptr : req1;

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            m_act <= 1'b1; m_t <= 0; m_pat <= 8'h00; m_vld <= 1'b0; m_ptr <= 1'b1;
        end else if (m_act) begin
            if (m_t == DONE_T) m_act <= 1'b0;
            else m_t <= m_t + 1;
        end else if (req0 || req1) begin
            m_own <= m_win; m_ptr <= m_win; m_pat <= m_win ? pat1 : pat0;
            m_vld <= 1'b1; m_act <= 1'b1; m_t <= 0;
            m_glog.push_back(int'(m_win));
        end
    end

    // {setn, resetn, clk_en, busy, ack1, ack0} the model demands now.
    function automatic logic [19:0] exp_vec();
        logic [7:0] s = 8'hFF, r = 8'hFF;
        logic c = 1'b1, b = 1'b0;
        logic [1:0] a = 2'b00;
        if (m_act) begin
            b = 1'b1; c = 1'b0;
            if (m_t < P) begin s = ~m_pat; r = m_pat; end
            else if (m_t < P + G) s = ~m_pat;
            else if (m_t == DONE_T) begin
                c = 1'b1;
                if (m_vld) a = m_own ? 2'b10 : 2'b01;
            end
        end
        return {s, r, c, b, a};
    endfunction

    task automatic chk(input string nm, input logic [19:0] got, input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %h, expected %h", nm, cyc, got, exp);
        end
    endtask

    task automatic compare_cycle();
        chk("cycle", {bank_setn, bank_resetn, bank_clk_en, busy, ack1, ack0}, exp_vec());
        chk("clk_gate_safe", 20'(bank_clk_en && !((&bank_setn) && (&bank_resetn))), 20'h0);
    endtask

    always @(negedge CLK) compare_cycle();

    task automatic wait_cyc(input int e);
        int g = 0;
        while (cyc < e && g < 1000) begin @(negedge CLK); g++; end
        if (cyc != e) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_edge: at edge %0d, expected %0d", cyc, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and init sequence
        #1 RESETN = 1'b0;
        @(negedge CLK); @(negedge CLK);
        chk("rst_resetn", 20'(bank_resetn), 20'h00);
        chk("rst_setn",   20'(bank_setn),   20'hFF);
        chk("rst_clk_en", 20'(bank_clk_en), 20'h0);
        chk("rst_busy",   20'(busy),        20'h1);
        RESETN = 1'b1;
        wait_cyc(1); chk("init_resetn_low", 20'(bank_resetn), 20'h00);
        wait_cyc(2); chk("init_resetn_rel", 20'(bank_resetn), 20'hFF);
        wait_cyc(4); chk("init_clk_off",    20'(bank_clk_en), 20'h0);
        wait_cyc(5); chk("init_clk_on",     20'(bank_clk_en), 20'h1);
                     chk("init_no_ack",     20'({ack1, ack0}), 20'h0);
        wait_cyc(6); chk("init_idle",       20'(busy), 20'h0);

        // Contention: both held, grants 7 cycles apart alternating 0,1,0,1
        req0 = 1'b1; req1 = 1'b1; pat0 = 8'h0F; pat1 = 8'hF0;
        wait_cyc(7);  chk("cont_g0_setn", 20'(bank_setn), 20'hF0);
                      chk("cont_g0_rstn", 20'(bank_resetn), 20'h0F);
        wait_cyc(12); chk("cont_ack_a", 20'({ack1, ack0}), 20'h1);
        wait_cyc(14); chk("cont_g1_setn", 20'(bank_setn), 20'h0F);
        wait_cyc(19); chk("cont_ack_b", 20'({ack1, ack0}), 20'h2);
        wait_cyc(26); chk("cont_ack_c", 20'({ack1, ack0}), 20'h1);
        wait_cyc(33); chk("cont_ack_d", 20'({ack1, ack0}), 20'h2);
        req0 = 1'b0; req1 = 1'b0;
        if (m_glog.size() == 4)
            chk("model_grant_order",
                20'({m_glog[0][0], m_glog[1][0], m_glog[2][0], m_glog[3][0]}), 20'h5);
        else
            chk("model_grant_count", 20'(m_glog.size()), 20'd4);

        // Single request, pattern changed after grant must be ignored
        wait_cyc(34);
        req0 = 1'b1; pat0 = 8'hA5;
        wait_cyc(35); chk("a5_setn", 20'(bank_setn), 20'h5A);
                      chk("a5_rstn", 20'(bank_resetn), 20'hA5);
        pat0 = 8'h33;
        wait_cyc(36); chk("a5_setn_held", 20'(bank_setn), 20'h5A);
        wait_cyc(37); chk("a5_rstn_rel",  20'(bank_resetn), 20'hFF);
                      chk("a5_setn_k2",   20'(bank_setn), 20'h5A);
        wait_cyc(38); chk("a5_setn_rel",  20'(bank_setn), 20'hFF);
        wait_cyc(39); chk("a5_clk_rec",   20'(bank_clk_en), 20'h0);
        wait_cyc(40); chk("a5_ack_clk",   20'({bank_clk_en, ack1, ack0}), 20'h5);
        req0 = 1'b0;
        wait_cyc(41); chk("a5_ack_gone",  20'({busy, ack1, ack0}), 20'h0);

        // Busy arrival: req1 raised during RELR of req0
        req0 = 1'b1; pat0 = 8'h3C;
        wait_cyc(44); req1 = 1'b1; pat1 = 8'h11;
        wait_cyc(45); pat1 = 8'h99;
        wait_cyc(47); chk("busy_ack0", 20'({ack1, ack0}), 20'h1);
        req0 = 1'b0;
        wait_cyc(48); chk("busy_idle", 20'(busy), 20'h0);
        wait_cyc(49); chk("busy_g1_setn", 20'(bank_setn), 20'h66);
                      chk("busy_g1_rstn", 20'(bank_resetn), 20'h99);

        // Abort during RELS of req1
        wait_cyc(52);
        #3 RESETN = 1'b0;
        #1 chk("abort_outs", {bank_setn, bank_resetn, bank_clk_en, busy, ack1, ack0},
                {8'hFF, 8'h00, 1'b0, 1'b1, 2'b00});
        @(negedge CLK); @(negedge CLK);
        RESETN = 1'b1;
        wait_cyc(5);  chk("abort_no_ack", 20'({ack1, ack0}), 20'h0);
        wait_cyc(7);  chk("regrant_setn", 20'(bank_setn), 20'h66);
        wait_cyc(12); chk("regrant_ack1", 20'({ack1, ack0}), 20'h2);
        req1 = 1'b0;

        // Extreme pattern 0xFF
        wait_cyc(13);
        req0 = 1'b1; pat0 = 8'hFF;
        wait_cyc(14); chk("ff_setn", 20'(bank_setn), 20'h00);
                      chk("ff_rstn", 20'(bank_resetn), 20'hFF);
        wait_cyc(16); chk("ff_relr", 20'({bank_setn, bank_resetn}), 20'h00FF);
        wait_cyc(19); chk("ff_ack", 20'({bank_clk_en, ack1, ack0}), 20'h5);
        req0 = 1'b0;

        // Extreme pattern 0x00
        wait_cyc(20);
        req0 = 1'b1; pat0 = 8'h00;
        wait_cyc(21); chk("00_setn", 20'(bank_setn), 20'hFF);
                      chk("00_rstn", 20'(bank_resetn), 20'h00);
        wait_cyc(23); chk("00_rels", 20'({bank_setn, bank_resetn}), 20'hFFFF);
        wait_cyc(26); chk("00_ack", 20'({bank_clk_en, ack1, ack0}), 20'h5);
        req0 = 1'b0;
        wait_cyc(28);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
